audio_mix_sequencer: RTL and testbench
======================================

Name: audio_mix_sequencer

Overview:
- Time-multiplexed stereo audio mixer controller for the sound path.
- Once per sample period it snapshots 8 unsigned 8-bit sources and sequences one shared 8x6 multiplier across 16 MAC steps (8 left, 8 right) using per-source, per-channel gains.
- It produces saturated 16-bit L/R samples for the PWM/codec output stage.
- Gains are CPU-programmable through a simple write port.

Parameters:
- DECIM, 512, sample period in clk24 cycles; legal range 32..65536.
- GAIN_W, 6, gain width; gain range is 0..63.
- RST_GAIN, 16, gain value loaded into every shadow and active gain register on reset.

Ports:
- clk24  in  1  system clock, 24 MHz.
- reset  in  1  synchronous, active-high reset.
- src_bus  in  64  8 sources, each unsigned 8-bit; source i is bits [8i+7:8i].
- cfg_we  in  1  gain write strobe, one cycle per write.
- cfg_addr  in  4  gain select: 0..7 = left gain of source 0..7; 8..15 = right gain of source 0..7.
- cfg_data  in  GAIN_W  gain value.
- mute  in  1  when 1, the results of the sample being finished are forced to 0.
- out_l  out  16  left sample, saturated unsigned.
- out_r  out  16  right sample, saturated unsigned.
- out_valid  out  1  one-cycle pulse when out_l/out_r update.
- busy  out  1  high while a sample is being computed (MAC or DONE state).

Behaviour:
- Clock and reset: one clock, clk24. Reset is synchronous and active-high.
- Reset values:
  - out_l = out_r = 0, out_valid = 0, busy = 0.
  - Decimator = 0; FSM = IDLE.
  - All 16 shadow and 16 active gains = RST_GAIN.
- Reset during MAC or DONE aborts the sample; no out_valid is generated.
- Decimator: free-running counter 0..DECIM-1, wrapping to 0. tick = (decimator == 0).
- The first tick after reset occurs in the first cycle after reset deasserts.
- Gain writes:
  - Always go to the shadow array; accepted every cycle, including while busy.
  - Active gains are copied from shadow only at the tick edge.
  - A write in the same cycle as a tick is included in that copy (write-through to the copy).
  - Gains therefore never change mid-sample.
- Snapshot: at the tick edge, src_bus is latched into 8 snapshot registers, the gains are copied, and both accumulators are cleared.
- FSM transitions:
  - IDLE -> MAC on tick.
  - MAC: step counter k = 0..15.
    - Source s = k>>1; even k targets the left accumulator, odd k the right.
    - Each step computes product = snap[s] * gain[ch][s] (14 bits), zero-extended and added to a 17-bit accumulator.
    - After k = 15, MAC -> DONE.
  - DONE -> IDLE. At this edge:
    - out_l = (acc_l > 65535) ? 65535 : acc_l[15:0]; same rule for out_r from acc_r.
    - mute overrides both outputs to 0; mute is sampled in the DONE cycle.
    - out_valid = 1 for exactly one cycle.
- Latency: tick in cycle n -> MAC cycles n+1..n+16 -> DONE cycle n+17 -> outputs and out_valid visible in cycle n+18.
- busy is high in cycles n+1..n+17.
- Width and overflow: worst case is 8*255*63 = 128520, which fits the 17-bit accumulator. Saturation happens only at output; accumulators never wrap.
- A tick can never land during busy because DECIM >= 32 > 18.
- A DECIM outside the legal range is a configuration error; no behaviour is defined for it.
- out_l/out_r hold their value between valid pulses.

Test Plan:
- Reset defaults: all sources 0x80, gains at reset (16) -> first out_valid 18 cycles after the first tick; out_l = out_r = 8*128*16 = 16384.
- Pan: set L gain of src2 = 63, R gain of src2 = 0, all others 0; src2 = 0xFF -> out_l = 16065, out_r = 0.
- Saturation: all sources 0xFF, all gains 63 -> out_l = out_r = 65535, not 62984 (wrapped).
- Mid-sample gain write: write L gain of src0 = 0 during busy -> current sample uses the old gain; the next sample reflects 0. Repeat with a write coincident with the tick -> the new gain applies immediately.
- Source change mid-sample: toggle src_bus during MAC -> output equals the value computed from the tick-time snapshot.
- Reset mid-MAC and mute: assert reset at MAC step 7 -> no out_valid, outputs 0, gains back to 16. With mute = 1 in DONE -> out_valid pulses and out_l = out_r = 0.

Source files
------------

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed stereo mixer: snapshots 8 sources each sample period, runs 16 MAC
// steps through one shared multiplier and emits saturated 16-bit L/R samples.
module audio_mix_sequencer #(
    parameter int DECIM    = 512,
    parameter int GAIN_W   = 6,
    parameter int RST_GAIN = 16
) (
    input  logic              clk24,
    input  logic              reset,
    input  logic [63:0]       src_bus,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [GAIN_W-1:0] cfg_data,
    input  logic              mute,
    output logic [15:0]       out_l,
    output logic [15:0]       out_r,
    output logic              out_valid,
    output logic              busy
);
    localparam int CNT_W  = (DECIM > 2) ? $clog2(DECIM) : 1;
    localparam int PROD_W = 8 + GAIN_W;
    localparam logic [CNT_W-1:0]  DEC_LAST  = CNT_W'(DECIM - 1);
    localparam logic [GAIN_W-1:0] GAIN_INIT = GAIN_W'(RST_GAIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [CNT_W-1:0]    dec_r;
    logic                tick_s;
    logic [GAIN_W-1:0]   shadow_r [16];
    logic [GAIN_W-1:0]   active_r [16];
    logic [7:0]          snap_r [8];
    logic [3:0]          step_r;
    logic [16:0]         acc_l_r;
    logic [16:0]         acc_r_r;
    logic [PROD_W-1:0]   product_s;

    function automatic logic [15:0] sat16(input logic [16:0] v);
        if (v[16]) begin
            sat16 = 16'hFFFF;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    assign tick_s    = (dec_r == {CNT_W{1'b0}});
    // Even steps use the left gain of source k>>1, odd steps the right gain.
    assign product_s = snap_r[step_r[3:1]] * active_r[{step_r[0], step_r[3:1]}];

    // Free-running sample-period counter.
    always_ff @(posedge clk24) begin
        if (reset) begin
            dec_r <= {CNT_W{1'b0}};
        end else if (dec_r == DEC_LAST) begin
            dec_r <= {CNT_W{1'b0}};
        end else begin
            dec_r <= dec_r + CNT_W'(1);
        end
    end

    // Shadow gains take every write; active gains copy at the tick with write-through.
    always_ff @(posedge clk24) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                shadow_r[i] <= GAIN_INIT;
                active_r[i] <= GAIN_INIT;
            end
        end else begin
            if (cfg_we) begin
                shadow_r[cfg_addr] <= cfg_data;
            end
            if (tick_s) begin
                for (int i = 0; i < 16; i++) begin
                    active_r[i] <= (cfg_we && (cfg_addr == 4'(i))) ? cfg_data : shadow_r[i];
                end
            end
        end
    end

    // Source snapshot taken once per sample period.
    always_ff @(posedge clk24) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                snap_r[i] <= 8'd0;
            end
        end else if (tick_s && (state_r == ST_IDLE)) begin
            for (int i = 0; i < 8; i++) begin
                snap_r[i] <= src_bus[8*i +: 8];
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                snap_r[i] <= snap_r[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_next_s = ST_MAC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (step_r == 4'd15) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register, MAC datapath and registered outputs.
    always_ff @(posedge clk24) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            step_r    <= 4'd0;
            acc_l_r   <= 17'd0;
            acc_r_r   <= 17'd0;
            out_l     <= 16'd0;
            out_r     <= 16'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            busy      <= (state_next_s != ST_IDLE);
            out_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        step_r  <= 4'd0;
                        acc_l_r <= 17'd0;
                        acc_r_r <= 17'd0;
                    end
                end
                ST_MAC: begin
                    step_r <= step_r + 4'd1;
                    if (step_r[0]) begin
                        acc_r_r <= acc_r_r + 17'(product_s);
                    end else begin
                        acc_l_r <= acc_l_r + 17'(product_s);
                    end
                end
                ST_DONE: begin
                    out_valid <= 1'b1;
                    out_l     <= mute ? 16'd0 : sat16(acc_l_r);
                    out_r     <= mute ? 16'd0 : sat16(acc_r_r);
                end
                default: begin
                    step_r <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Bench for audio_mix_sequencer: directed vector table, corner sequences and random
// stimulus, all checked cycle by cycle against an arithmetic model of the mixer.
module tb_audio_mix_sequencer;
    localparam int DECIM    = 32;
    localparam int GAIN_W   = 6;
    localparam int RST_GAIN = 16;

    logic              clk24 = 1'b0;
    logic              reset = 1'b1;
    logic [63:0]       src_bus = 64'd0;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = 4'd0;
    logic [GAIN_W-1:0] cfg_data = '0;
    logic              mute = 1'b0;
    logic [15:0]       out_l, out_r;
    logic              out_valid, busy;

    audio_mix_sequencer #(.DECIM(DECIM), .GAIN_W(GAIN_W), .RST_GAIN(RST_GAIN)) dut (
        .clk24(clk24), .reset(reset), .src_bus(src_bus), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .mute(mute),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk24 = ~clk24;

    int n_cmp = 0;
    int n_bad = 0;
    int ci = 0;
    int m_shadow [16];
    int m_act [16];
    int m_snap [8];
    bit m_active = 1'b0;
    int m_tick = 0;
    int m_pl = 0, m_pr = 0;
    int exp_l = 0, exp_r = 0;

    typedef struct {
        logic [7:0] src_all;
        logic [7:0] src2;
        int         gain_all;
        int         gl2;
        int         gr2;
        bit         mute_v;
        bit         do_cfg;
        int         exp_l;
        int         exp_r;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ci);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One clock: update the model from the inputs of this cycle, then check the DUT.
    task automatic cycle();
        bit rst_now;
        bit ev, eb;
        int sl, sr;
        rst_now = reset;
        if (!rst_now) begin
            if (ci % DECIM == 0) begin
                for (int s = 0; s < 8; s++) m_snap[s] = int'(src_bus[8*s +: 8]);
                for (int g = 0; g < 16; g++)
                    m_act[g] = (cfg_we && int'(cfg_addr) == g) ? int'(cfg_data) : m_shadow[g];
                m_active = 1'b1;
                m_tick = ci;
            end
            if (m_active && ci == m_tick + 17) begin
                sl = 0; sr = 0;
                for (int s = 0; s < 8; s++) begin
                    sl += m_snap[s] * m_act[s];
                    sr += m_snap[s] * m_act[8 + s];
                end
                m_pl = mute ? 0 : sat(sl);
                m_pr = mute ? 0 : sat(sr);
            end
            if (cfg_we) m_shadow[cfg_addr] = int'(cfg_data);
        end
        @(posedge clk24);
        #1;
        if (rst_now) begin
            ci = 0;
            m_active = 1'b0;
            exp_l = 0;
            exp_r = 0;
            for (int g = 0; g < 16; g++) m_shadow[g] = RST_GAIN;
        end else begin
            ci++;
        end
        ev = !rst_now && m_active && (ci == m_tick + 18);
        eb = !rst_now && m_active && (ci >= m_tick + 1) && (ci <= m_tick + 17);
        if (ev) begin
            exp_l = m_pl;
            exp_r = m_pr;
        end
        chk("out_valid", int'(out_valid), int'(ev));
        chk("busy", int'(busy), int'(eb));
        chk("out_l", int'(out_l), exp_l);
        chk("out_r", int'(out_r), exp_r);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_we = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic write_gain(input int addr, input int data);
        cfg_we = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = GAIN_W'(data);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * DECIM + 4; i++) begin
            cycle();
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: out_valid not seen, expected a pulse within %0d cycles", name, 2 * DECIM + 4);
        end
    endtask

    task automatic run_to_tick();
        for (int i = 0; i < 2 * DECIM && (ci % DECIM) != 0; i++) cycle();
    endtask

    initial begin
        int t;
        vecs[0] = '{8'h80, 8'h80, 16, 16, 16, 1'b0, 1'b0, 16384, 16384};
        vecs[1] = '{8'h11, 8'hFF,  0, 63,  0, 1'b0, 1'b1, 16065, 0};
        vecs[2] = '{8'hFF, 8'hFF, 63, 63, 63, 1'b0, 1'b1, 65535, 65535};
        vecs[3] = '{8'h80, 8'h80, 16, 16, 16, 1'b1, 1'b1, 0, 0};
        vecs[4] = '{8'h40, 8'h40, 10, 10, 33, 1'b0, 1'b1, 5120, 6592};
        vecs[5] = '{8'hFF, 8'hFF, 32, 34, 32, 1'b0, 1'b1, 65535, 65280};
        for (int g = 0; g < 16; g++) m_shadow[g] = RST_GAIN;

        for (int v = 0; v < 6; v++) begin
            src_bus = {8{vecs[v].src_all}};
            src_bus[23:16] = vecs[v].src2;
            mute = vecs[v].mute_v;
            do_reset();
            if (vecs[v].do_cfg) begin
                for (int g = 0; g < 16; g++)
                    write_gain(g, (g == 2) ? vecs[v].gl2 : (g == 10) ? vecs[v].gr2 : vecs[v].gain_all);
            end
            wait_valid("vec_first");
            wait_valid("vec_second");
            chk($sformatf("vec%0d_l", v), int'(out_l), vecs[v].exp_l);
            chk($sformatf("vec%0d_r", v), int'(out_r), vecs[v].exp_r);
        end

        // Gain write while busy applies only to the following sample.
        src_bus = {8{8'h80}};
        mute = 1'b0;
        do_reset();
        while (ci < 5) cycle();
        write_gain(0, 0);
        wait_valid("midwr_a");
        chk("midwr_old_l", int'(out_l), 16384);
        wait_valid("midwr_b");
        chk("midwr_new_l", int'(out_l), 14336);
        chk("midwr_new_r", int'(out_r), 16384);
        // Write coincident with the tick is used immediately.
        run_to_tick();
        write_gain(1, 0);
        wait_valid("tickwr");
        chk("tickwr_l", int'(out_l), 12288);

        // Source changes during MAC do not affect the snapshot.
        do_reset();
        while (ci < 4) cycle();
        src_bus = {8{8'hFF}};
        wait_valid("srcchg_a");
        chk("srcchg_l", int'(out_l), 16384);
        chk("srcchg_r", int'(out_r), 16384);
        wait_valid("srcchg_b");
        chk("srcchg_next_l", int'(out_l), 32640);

        // Reset at MAC step 7 aborts the sample and restores gains.
        src_bus = {8{8'h80}};
        run_to_tick();
        t = ci;
        write_gain(0, 0);
        while (ci < t + 8) cycle();
        reset = 1'b1;
        cycle();
        chk("rstmac_l", int'(out_l), 0);
        chk("rstmac_busy", int'(busy), 0);
        reset = 1'b0;
        wait_valid("rstmac_after");
        chk("rstmac_gain_l", int'(out_l), 16384);

        // Mute is sampled only in the DONE cycle.
        run_to_tick();
        t = ci;
        mute = 1'b1;
        while (ci < t + 17) cycle();
        mute = 1'b0;
        wait_valid("mute_off");
        chk("mute_off_l", int'(out_l), 16384);
        run_to_tick();
        t = ci;
        while (ci < t + 17) cycle();
        mute = 1'b1;
        wait_valid("mute_on");
        mute = 1'b0;
        chk("mute_on_l", int'(out_l), 0);
        chk("mute_on_r", int'(out_r), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            src_bus = {$urandom, $urandom};
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_data = GAIN_W'($urandom_range(0, 63));
            mute = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 249) == 0);
            cycle();
        end
        reset = 1'b0;
        cfg_we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
